// File: rtl/rv32i_multicycle_core.sv
// rtl/rv32i_multicycle_core.sv - multi-cycle RV32I/RV32E core with handshaked memory ports
//
// Purpose: FETCH/EXEC/MEM/WB state machine executing the RV32I base integer
// subset (LUI, AUIPC, JAL, JALR, branches, loads, stores, ALU/ALUi). Both memory
// ports use a request/ready handshake, so any number of wait states is tolerated.
// Illegal encodings, misaligned accesses/targets and out-of-range register
// indices halt the core until reset without committing anything.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   o_ireq/o_iaddr         fetch request and address (= pc)
//   i_irdy/i_idata         fetch complete, instruction word
//   o_dreq/o_daddr         data request and byte address
//   i_drdy/i_drdata        data access complete, aligned read word
//   o_dwdata/o_dwe         lane-replicated store data, byte enables (0 for loads)
//   o_retire               one-cycle pulse per committed instruction
//   o_halted               sticky trap indication
//   o_registers            {x[NREGS-1], ..., x0} flattened
module rv32i_multicycle_core #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          NREGS    = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   output logic                  o_ireq,
   output logic [31:0]           o_iaddr,
   input  logic                  i_irdy,
   input  logic [31:0]           i_idata,
   output logic                  o_dreq,
   output logic [31:0]           o_daddr,
   input  logic                  i_drdy,
   input  logic [31:0]           i_drdata,
   output logic [31:0]           o_dwdata,
   output logic [3:0]            o_dwe,
   output logic                  o_retire,
   output logic                  o_halted,
   output logic [32*NREGS-1:0]   o_registers
);

   localparam int         IW = $clog2(NREGS);
   localparam logic [5:0] NR = 6'(NREGS);

   typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t      r_state;
   logic [31:0] r_pc, r_ir, r_npc, r_result, r_daddr, r_dwdata;
   logic [3:0]  r_dwe;
   logic        r_ireq, r_dreq, r_retire, r_halted, r_wr;
   logic [31:0] r_regs [NREGS];

   // instruction fields and immediates
   logic [6:0]  w_op, w_f7;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic [2:0]  w_f3;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [31:0] w_a, w_b, w_pc4, w_ea;

   assign w_op    = r_ir[6:0];
   assign w_rd    = r_ir[11:7];
   assign w_f3    = r_ir[14:12];
   assign w_rs1   = r_ir[19:15];
   assign w_rs2   = r_ir[24:20];
   assign w_f7    = r_ir[31:25];
   assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
   assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
   assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
   assign w_imm_u = {r_ir[31:12], 12'd0};
   assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

   // out-of-range indices trap in EXEC, so the truncated read is never used then
   assign w_a   = r_regs[w_rs1[IW-1:0]];
   assign w_b   = r_regs[w_rs2[IW-1:0]];
   assign w_pc4 = r_pc + 32'd4;

   function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                       input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  alu = alt ? a - b : a + b;
         3'b001:  alu = a << b[4:0];
         3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
         3'b011:  alu = {31'd0, a < b};
         3'b100:  alu = a ^ b;
         3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  alu = a | b;
         default: alu = a & b;
      endcase
   endfunction

   logic        w_illegal, w_wr, w_jump, w_load, w_store, w_use1, w_use2, w_used, w_taken;
   logic [31:0] w_res, w_npc;

   always_comb begin
      w_illegal = 1'b0;
      w_wr      = 1'b0;
      w_jump    = 1'b0;
      w_load    = 1'b0;
      w_store   = 1'b0;
      w_use1    = 1'b0;
      w_use2    = 1'b0;
      w_used    = 1'b0;
      w_taken   = 1'b0;
      w_res     = 32'd0;
      w_npc     = w_pc4;
      case (w_op)
         7'b0110111: begin
            w_wr = 1'b1; w_used = 1'b1; w_res = w_imm_u;
         end
         7'b0010111: begin
            w_wr = 1'b1; w_used = 1'b1; w_res = r_pc + w_imm_u;
         end
         7'b1101111: begin
            w_wr = 1'b1; w_used = 1'b1; w_res = w_pc4;
            w_npc = r_pc + w_imm_j; w_jump = 1'b1;
         end
         7'b1100111: begin
            // target comes from the pre-writeback rs1, so rd == rs1 is safe
            w_wr = 1'b1; w_used = 1'b1; w_use1 = 1'b1; w_res = w_pc4;
            w_npc = (w_a + w_imm_i) & ~32'd1; w_jump = 1'b1;
            w_illegal = (w_f3 != 3'b000);
         end
         7'b1100011: begin
            w_use1 = 1'b1; w_use2 = 1'b1;
            case (w_f3)
               3'b000:  w_taken = (w_a == w_b);
               3'b001:  w_taken = (w_a != w_b);
               3'b100:  w_taken = ($signed(w_a) <  $signed(w_b));
               3'b101:  w_taken = ($signed(w_a) >= $signed(w_b));
               3'b110:  w_taken = (w_a <  w_b);
               3'b111:  w_taken = (w_a >= w_b);
               default: w_illegal = 1'b1;
            endcase
            w_jump = w_taken;
            if (w_taken) w_npc = r_pc + w_imm_b;
         end
         7'b0000011: begin
            w_load = 1'b1; w_wr = 1'b1; w_use1 = 1'b1; w_used = 1'b1;
            w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         7'b0100011: begin
            w_store = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
            w_illegal = w_f3[2] || (w_f3 == 3'b011);
         end
         7'b0010011: begin
            w_wr = 1'b1; w_use1 = 1'b1; w_used = 1'b1;
            // only the shift-right form carries a funct7 selector for immediates
            w_res = alu(w_f3, (w_f3 == 3'b101) && r_ir[30], w_a, w_imm_i);
            w_illegal = ((w_f3 == 3'b001) && (w_f7 != 7'd0)) ||
                        ((w_f3 == 3'b101) && (w_f7 != 7'd0) && (w_f7 != 7'b0100000));
         end
         7'b0110011: begin
            w_wr = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_used = 1'b1;
            w_res = alu(w_f3, r_ir[30], w_a, w_b);
            w_illegal = !((w_f7 == 7'd0) ||
                          ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
         end
         default: w_illegal = 1'b1;
      endcase
   end

   logic w_misal, w_tmis, w_badidx, w_trap;

   assign w_ea     = w_a + (w_store ? w_imm_s : w_imm_i);
   assign w_misal  = (w_load || w_store) &&
                     (((w_f3[1:0] == 2'b01) && w_ea[0]) ||
                      ((w_f3[1:0] == 2'b10) && (w_ea[1:0] != 2'b00)));
   assign w_tmis   = w_jump && (w_npc[1:0] != 2'b00);
   assign w_badidx = (w_use1 && ({1'b0, w_rs1} >= NR)) ||
                     (w_use2 && ({1'b0, w_rs2} >= NR)) ||
                     (w_used && ({1'b0, w_rd}  >= NR));
   assign w_trap   = w_illegal || w_misal || w_tmis || w_badidx;

   logic [3:0]  w_st_dwe;
   logic [31:0] w_st_data, w_ld_sh, w_ld_val;

   always_comb begin
      w_st_dwe  = 4'hF;
      w_st_data = w_b;
      case (w_f3[1:0])
         2'b00: begin
            w_st_dwe  = 4'b0001 << w_ea[1:0];
            w_st_data = {4{w_b[7:0]}};
         end
         2'b01: begin
            w_st_dwe  = 4'b0011 << w_ea[1:0];
            w_st_data = {2{w_b[15:0]}};
         end
         default: ;
      endcase
   end

   // read word is aligned; shift the addressed lane down to bit 0
   assign w_ld_sh = i_drdata >> {r_daddr[1:0], 3'b000};

   always_comb begin
      case (r_ir[14:12])
         3'b000:  w_ld_val = {{24{w_ld_sh[7]}}, w_ld_sh[7:0]};
         3'b100:  w_ld_val = {24'd0, w_ld_sh[7:0]};
         3'b001:  w_ld_val = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
         3'b101:  w_ld_val = {16'd0, w_ld_sh[15:0]};
         default: w_ld_val = w_ld_sh;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= S_FETCH;
         r_pc     <= RESET_PC;
         r_ir     <= '0;
         r_npc    <= '0;
         r_result <= '0;
         r_wr     <= 1'b0;
         r_ireq   <= 1'b0;
         r_dreq   <= 1'b0;
         r_daddr  <= '0;
         r_dwdata <= '0;
         r_dwe    <= '0;
         r_retire <= 1'b0;
         r_halted <= 1'b0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               // the first cycle out of reset only raises the request
               if (r_ireq && i_irdy) begin
                  r_ir    <= i_idata;
                  r_ireq  <= 1'b0;
                  r_state <= S_EXEC;
               end else begin
                  r_ireq  <= 1'b1;
               end
            end
            S_EXEC: begin
               if (w_trap) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else if (w_load || w_store) begin
                  r_daddr  <= w_ea;
                  r_dreq   <= 1'b1;
                  r_dwe    <= w_store ? w_st_dwe : 4'b0000;
                  r_dwdata <= w_store ? w_st_data : 32'd0;
                  r_wr     <= w_load;
                  r_npc    <= w_pc4;
                  r_state  <= S_MEM;
               end else begin
                  r_result <= w_res;
                  r_wr     <= w_wr;
                  r_npc    <= w_npc;
                  r_retire <= 1'b1;
                  r_state  <= S_WB;
               end
            end
            S_MEM: begin
               if (i_drdy) begin
                  r_dreq   <= 1'b0;
                  r_dwe    <= 4'b0000;
                  r_result <= w_ld_val;
                  r_retire <= 1'b1;
                  r_state  <= S_WB;
               end
            end
            S_WB: begin
               if (r_wr && (r_ir[11:7] != 5'd0)) r_regs[r_ir[7 +: IW]] <= r_result;
               r_pc     <= r_npc;
               r_retire <= 1'b0;
               r_ireq   <= 1'b1;
               r_state  <= S_FETCH;
            end
            S_HALT: begin
               r_ireq   <= 1'b0;
               r_dreq   <= 1'b0;
               r_dwe    <= 4'b0000;
               r_retire <= 1'b0;
               r_halted <= 1'b1;
            end
            default: r_state <= S_HALT;
         endcase
      end
   end

   assign o_ireq   = r_ireq;
   assign o_iaddr  = r_pc;
   assign o_dreq   = r_dreq;
   assign o_daddr  = r_daddr;
   assign o_dwdata = r_dwdata;
   assign o_dwe    = r_dwe;
   assign o_retire = r_retire;
   assign o_halted = r_halted;

   for (genvar g = 0; g < NREGS; g++) begin : g_regs
      assign o_registers[32*g +: 32] = r_regs[g];
   end

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// tb/tb_rv32i_multicycle_core.sv - directed self-checking bench for rv32i_multicycle_core
module tb_rv32i_multicycle_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          ireq, irdy, dreq, drdy, retire, halted;
   logic [31:0]   iaddr, idata, daddr, drdata, dwdata;
   logic [3:0]    dwe;
   logic [1023:0] regs_flat;

   logic          e_ireq, e_irdy, e_dreq, e_drdy, e_retire, e_halted;
   logic [31:0]   e_iaddr, e_idata, e_daddr, e_drdata, e_dwdata;
   logic [3:0]    e_dwe;
   logic [511:0]  e_regs_flat;

   rv32i_multicycle_core #(.RESET_PC(32'h100), .NREGS(32)) u_dut (
      .i_clk(clk), .i_reset(reset),
      .o_ireq(ireq), .o_iaddr(iaddr), .i_irdy(irdy), .i_idata(idata),
      .o_dreq(dreq), .o_daddr(daddr), .i_drdy(drdy), .i_drdata(drdata),
      .o_dwdata(dwdata), .o_dwe(dwe), .o_retire(retire), .o_halted(halted),
      .o_registers(regs_flat));

   rv32i_multicycle_core #(.RESET_PC(32'h0), .NREGS(16)) u_dut_e (
      .i_clk(clk), .i_reset(reset),
      .o_ireq(e_ireq), .o_iaddr(e_iaddr), .i_irdy(e_irdy), .i_idata(e_idata),
      .o_dreq(e_dreq), .o_daddr(e_daddr), .i_drdy(e_drdy), .i_drdata(e_drdata),
      .o_dwdata(e_dwdata), .o_dwe(e_dwe), .o_retire(e_retire), .o_halted(e_halted),
      .o_registers(e_regs_flat));

   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   logic [31:0] fetch_log [16];
   int          ret_at [16];
   int          cyc = 0, dwait = 0, dcnt = 0;
   int          fetch_n = 0, ret_n = 0, acc_n = 0, e_ret_n = 0, first_ireq = -1;
   logic [3:0]  last_dwe = 4'd0;
   logic [31:0] last_dwdata = 32'd0, last_daddr = 32'd0;
   int          n_tests = 0, n_fail = 0;

   logic [31:0] exp_pc [9] = '{32'h100, 32'h104, 32'h10C, 32'h110, 32'h108,
                               32'h114, 32'h118, 32'h120, 32'h124};

   always @(posedge clk) cyc <= cyc + 1;

   // memory models and event logging, evaluated away from the active edge
   always @(negedge clk) begin
      if (reset) begin
         irdy = 1'b0; drdy = 1'b0; dcnt = 0; e_irdy = 1'b0;
         idata = 32'd0; drdata = 32'd0;
      end else begin
         if (ireq) begin
            if (fetch_n < 16) fetch_log[fetch_n] = iaddr;
            fetch_n++;
            if (first_ireq < 0) first_ireq = cyc;
         end
         irdy  = ireq;
         idata = imem[iaddr[7:2]];
         if (retire) begin
            if (ret_n < 16) ret_at[ret_n] = cyc;
            ret_n++;
         end
         if (dreq) begin
            if (dcnt == dwait) begin
               drdy   = 1'b1;
               dcnt   = 0;
               acc_n++;
               drdata = dmem[daddr[7:2]];
               if (dwe != 4'd0) begin
                  for (int b = 0; b < 4; b++)
                     if (dwe[b]) dmem[daddr[7:2]][8*b +: 8] = dwdata[8*b +: 8];
                  last_dwe = dwe; last_dwdata = dwdata; last_daddr = daddr;
               end
            end else begin
               drdy = 1'b0;
               dcnt++;
            end
         end else begin
            drdy = 1'b0;
            dcnt = 0;
         end
         e_irdy  = e_ireq;
         e_idata = e_iaddr[2] ? 32'h002088B3 : 32'h00700793;  // add x17,x1,x2 / addi x15,x0,7
         if (e_retire) e_ret_n++;
      end
      e_drdy = 1'b0;
      e_drdata = 32'd0;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] xreg(input int i);
      return regs_flat[32*i +: 32];
   endfunction

   function automatic logic [31:0] e_xreg(input int i);
      return e_regs_flat[32*i +: 32];
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) begin
         imem[i] = 32'd0;
         dmem[i] = 32'd0;
      end
   endtask

   task automatic assert_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      fetch_n = 0; ret_n = 0; acc_n = 0; e_ret_n = 0; first_ireq = -1;
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic run_until_halt(input int budget);
      for (int i = 0; i < budget && !halted; i++) @(negedge clk);
      check_eq("halted", {31'd0, halted}, 32'd1);
   endtask

   initial begin
      // ---- reset state, NOP latency, x0 immutability, RV32E index trap ----
      clear_mem();
      imem[0] = 32'h00000013;   // addi x0,x0,0
      imem[1] = 32'h00700013;   // addi x0,x0,7
      dwait = 0;
      assert_reset();
      #1;
      check_eq("rst_ireq",   {31'd0, ireq},   32'd0);
      check_eq("rst_dreq",   {31'd0, dreq},   32'd0);
      check_eq("rst_dwe",    {28'd0, dwe},    32'd0);
      check_eq("rst_daddr",  daddr,           32'd0);
      check_eq("rst_dwdata", dwdata,          32'd0);
      check_eq("rst_retire", {31'd0, retire}, 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      release_reset();
      run_until_halt(200);
      check_eq("first_iaddr", fetch_log[0], 32'h100);
      check_eq("nop_latency", 32'(ret_at[0] - first_ireq + 1), 32'd3);
      check_eq("nop_retires", 32'(ret_n), 32'd2);
      check_eq("x0_zero", xreg(0), 32'd0);
      repeat (4) @(negedge clk);
      check_eq("e_x15", e_xreg(15), 32'd7);
      check_eq("e_halted", {31'd0, e_halted}, 32'd1);
      check_eq("e_retires", 32'(e_ret_n), 32'd1);

      // ---- ALU immediates and unsigned compare ----
      clear_mem();
      imem[0] = 32'hFFB00093;   // addi x1,x0,-5
      imem[1] = 32'h4010D113;   // srai x2,x1,1
      imem[2] = 32'h001031B3;   // sltu x3,x0,x1
      assert_reset();
      release_reset();
      run_until_halt(200);
      check_eq("alu_x1", xreg(1), 32'hFFFFFFFB);
      check_eq("alu_x2", xreg(2), 32'hFFFFFFFD);
      check_eq("alu_x3", xreg(3), 32'd1);
      check_eq("alu_retires", 32'(ret_n), 32'd3);
      check_eq("alu_9cyc", 32'(ret_at[2] - first_ireq + 1), 32'd9);

      // ---- stores, loads with wait states, misaligned halfword trap ----
      clear_mem();
      imem[0] = 32'h808182B7;   // lui  x5,0x80818
      imem[1] = 32'h28328293;   // addi x5,x5,0x283
      imem[2] = 32'h02502023;   // sw   x5,0x20(x0)
      imem[3] = 32'h02100203;   // lb   x4,0x21(x0)
      imem[4] = 32'h02104303;   // lbu  x6,0x21(x0)
      imem[5] = 32'h0AB00393;   // addi x7,x0,0xAB
      imem[6] = 32'h027009A3;   // sb   x7,0x33(x0)
      imem[7] = 32'h027018A3;   // sh   x7,0x31(x0)
      dwait = 3;
      assert_reset();
      release_reset();
      run_until_halt(300);
      check_eq("sw_word", dmem[8], 32'h80818283);
      check_eq("lb_x4", xreg(4), 32'hFFFFFF82);
      check_eq("lbu_x6", xreg(6), 32'h00000082);
      check_eq("lb_7cyc", 32'(ret_at[3] - ret_at[2]), 32'd7);
      check_eq("sb_dwe", {28'd0, last_dwe}, 32'h8);
      check_eq("sb_dwdata", last_dwdata, 32'hABABABAB);
      check_eq("sb_daddr", last_daddr, 32'h33);
      check_eq("sb_word", dmem[12], 32'hAB000000);
      check_eq("sh_trap_retires", 32'(ret_n), 32'd7);
      check_eq("sh_trap_accesses", 32'(acc_n), 32'd4);
      check_eq("halt_dwe", {28'd0, dwe}, 32'd0);
      check_eq("halt_dreq", {31'd0, dreq}, 32'd0);
      check_eq("halt_ireq", {31'd0, ireq}, 32'd0);

      // ---- control flow: jal, backward beq, untaken bne, jalr rd==rs1 ----
      clear_mem();
      imem[0] = 32'h12000093;   // 100: addi x1,x0,0x120
      imem[1] = 32'h0080006F;   // 104: jal  x0,+8
      imem[2] = 32'h00C0006F;   // 108: jal  x0,+12
      imem[3] = 32'h00110113;   // 10C: addi x2,x2,1
      imem[4] = 32'hFE000CE3;   // 110: beq  x0,x0,-8
      imem[5] = 32'h00001463;   // 114: bne  x0,x0,+8
      imem[6] = 32'h000080E7;   // 118: jalr x1,x1,0
      imem[7] = 32'h00100493;   // 11C: addi x9,x0,1 (skipped)
      imem[8] = 32'h00200513;   // 120: addi x10,x0,2
      dwait = 0;
      assert_reset();
      release_reset();
      run_until_halt(300);
      for (int i = 0; i < 9; i++) check_eq($sformatf("pc_seq%0d", i), fetch_log[i], exp_pc[i]);
      check_eq("br_fetches", 32'(fetch_n), 32'd9);
      check_eq("jalr_x1", xreg(1), 32'h11C);
      check_eq("loop_x2", xreg(2), 32'd1);
      check_eq("skip_x9", xreg(9), 32'd0);
      check_eq("target_x10", xreg(10), 32'd2);
      check_eq("br_retires", 32'(ret_n), 32'd8);

      // ---- reset asserted while a store waits in MEM ----
      clear_mem();
      imem[0] = 32'h00500093;   // addi x1,x0,5
      imem[1] = 32'h04102023;   // sw   x1,0x40(x0)
      dwait = 20;
      assert_reset();
      release_reset();
      for (int i = 0; i < 50 && !dreq; i++) @(negedge clk);
      check_eq("mid_dreq_seen", {31'd0, dreq}, 32'd1);
      check_eq("mid_x1_before", xreg(1), 32'd5);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      fetch_n = 0; ret_n = 0; acc_n = 0; first_ireq = -1;
      #1;
      check_eq("mid_dreq_drop", {31'd0, dreq}, 32'd0);
      check_eq("mid_dwe_drop", {28'd0, dwe}, 32'd0);
      check_eq("mid_x1_cleared", xreg(1), 32'd0);
      check_eq("mid_iaddr_rst", iaddr, 32'h100);
      release_reset();
      for (int i = 0; i < 20 && fetch_n == 0; i++) @(negedge clk);
      check_eq("mid_refetch", 32'(fetch_n), 32'd1);
      check_eq("mid_refetch_pc", fetch_log[0], 32'h100);
      check_eq("mid_no_store", dmem[16], 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
